// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared FSM state type, BCD digit width and digit-count helper for bin2bcd_n.
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_W = 4;
  // Smallest digit count whose decimal range covers 2^bw - 1.
  function automatic int min_dig(input int bw);
    longint unsigned lim, p;
    int d;
    lim = (64'd1 << bw) - 64'd1;
    p = 64'd1;
    d = 0;
    while (p <= lim) begin
      p = p * 64'd10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/bin2bcd_n_digit_adj.sv
// bcd_digit_adj: double-dabble correction, adds 3 to a BCD digit greater than 4.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit
);
  always_comb o_digit = (i_digit > 4'd4) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bin2bcd_n.sv
// bin2bcd_n: sequential double-dabble binary-to-BCD converter, BIN_W shift cycles per result.
// Optional two's-complement input with sign output when BIN2BCD_SIGNED_EN is defined.
module bin2bcd_n
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 12,
  parameter int DIG   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_W-1:0]     bin,
  output logic                 ready,
  output logic [BCD_W*DIG-1:0] bcd,
  output logic                 valid
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                 sign
`endif
);
  localparam int CW = $clog2(BIN_W);
  localparam int BW = BCD_W * DIG;
  if (DIG < min_dig(BIN_W)) begin : g_dig_check
    $error("bin2bcd_n: DIG too small for BIN_W");
  end
  state_t r_state;
  logic [BW-1:0] r_work, w_adj, w_next;
  logic [BIN_W-1:0] r_sr, w_load;
  logic [CW-1:0] r_cnt;
  for (genvar d = 0; d < DIG; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit(r_work[d*BCD_W +: BCD_W]),
      .o_digit(w_adj[d*BCD_W +: BCD_W])
    );
  end
  assign w_next = {w_adj[BW-2:0], r_sr[BIN_W-1]};
`ifdef BIN2BCD_SIGNED_EN
  logic r_neg;
  assign w_load = bin[BIN_W-1] ? -bin : bin;
`else
  assign w_load = bin;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      ready   <= 1'b1;
      valid   <= 1'b0;
      bcd     <= '0;
      r_work  <= '0;
      r_sr    <= '0;
      r_cnt   <= '0;
`ifdef BIN2BCD_SIGNED_EN
      r_neg   <= 1'b0;
      sign    <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      if (r_state == SHIFT) begin
        r_work <= w_next;
        r_sr   <= r_sr << 1;
        if (r_cnt == '0) begin
          r_state <= DONE;
          ready   <= 1'b1;
          valid   <= 1'b1;
          bcd     <= w_next;
`ifdef BIN2BCD_SIGNED_EN
          sign    <= r_neg;
`endif
        end else
          r_cnt <= r_cnt - CW'(1);
      end else if (start) begin
        r_state <= SHIFT;
        ready   <= 1'b0;
        r_sr    <= w_load;
        r_work  <= '0;
        r_cnt   <= CW'(BIN_W - 1);
`ifdef BIN2BCD_SIGNED_EN
        r_neg   <= bin[BIN_W-1];
`endif
      end else
        r_state <= IDLE;
    end
endmodule

// File: doc/bin2bcd_n.md
BIN2BCD_N -- requirements
Module: bin2bcd_n

Interface
REQ-001 BIN_W, 12, binary input width in bits (>= 4).
REQ-002 DIG, 4, BCD output digit count; SHALL satisfy 10^DIG > 2^BIN_W - 1, enforced by an elaboration-time assertion.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  conversion request; accepted only while ready=1.
REQ-006 bin  input  BIN_W  binary operand, sampled on the accepting edge.
REQ-007 ready  output  1  high in IDLE and DONE, low in SHIFT.
REQ-008 bcd  output  4*DIG  packed BCD result, digit 0 in bits [3:0].
REQ-009 valid  output  1  one-cycle pulse marking bcd as a fresh result.
REQ-010 sign  output  1  result sign; present only with BIN2BCD_SIGNED_EN.

Function
REQ-011 FSM states: IDLE, SHIFT, DONE.
- IDLE->SHIFT on start.
- SHIFT->DONE after exactly BIN_W shift cycles.
- DONE->SHIFT on start, else DONE->IDLE.
REQ-012 Accept: on the edge where start=1 and ready=1, latch bin into an internal shift register, clear the working BCD register, and load bit counter with BIN_W-1.
REQ-013 Each SHIFT cycle applies double-dabble:
- add 3 to every working digit >4;
- shift left one bit, MSB of the shift register first, into digit 0 bit 0.
REQ-014 Latency: start sampled at end of cycle 0; cycles 1..BIN_W are SHIFT; valid=1 in cycle BIN_W+1, i.e. 13 cycles for BIN_W=12.
REQ-015 On DONE entry, bcd SHALL load the final working value and hold it stable until the next DONE entry; bcd is never cleared by a new start.
REQ-016 start while ready=0 SHALL be ignored with no effect on state, counter or operands.
REQ-017 start in the DONE cycle SHALL be accepted: valid still pulses that cycle and SHIFT begins next cycle (back-to-back, one result per BIN_W+1 cycles).
REQ-018 Digit arithmetic is 4-bit modulo. No digit of the working register may exceed 9 after correction. Bits above 4*DIG are discarded (unreachable given REQ-002).
REQ-019 Bit counter width SHALL be clog2(BIN_W). It SHALL not wrap; the SHIFT exit is decoded at count 0.

Reset
REQ-020 rst=1 SHALL force the following regardless of state or mid-conversion progress:
- IDLE;
- ready=1, valid=0, bcd=0, sign=0;
- internal registers cleared.
REQ-021 A conversion interrupted by reset SHALL produce no valid pulse after reset release.
REQ-022 The first start after reset release SHALL be accepted on the first clock edge.

Configuration
REQ-023 Macro BIN2BCD_SIGNED_EN.
REQ-024 Defined:
- bin is two's complement;
- on accept, magnitude |bin| (BIN_W-bit unsigned, so -2^(BIN_W-1) is exact) is latched;
- sign latched as bin[BIN_W-1] and presented alongside bcd with identical update timing.
REQ-025 Undefined: bin is unsigned, sign port absent, no negate logic synthesised.

Structure
REQ-026 Shared package bin2bcd_pkg SHALL hold:
- FSM state enum (IDLE/SHIFT/DONE);
- BCD digit width constant (4);
- constant function returning minimum DIG for a given BIN_W, used by the REQ-002 assertion.
REQ-027 One sub-module, bcd_digit_adj (combinational add-3-if->4 on one digit), instantiated DIG times by generate.

Verification
REQ-028 BIN_W=12, DIG=4: bin=4095, start 1 cycle -> valid exactly 13 cycles later, bcd=16'h4095, ready low for cycles 1..12.
REQ-029 bin=0 -> bcd=16'h0000 with valid. Then start with bin=9 during SHIFT of a 1234 conversion -> ignored, result 16'h1234.
REQ-030 Back-to-back: 100 accepted, then 999 started in the DONE cycle -> valid pulses 13 cycles apart with 16'h0100 then 16'h0999; bcd holds between pulses.
REQ-031 rst asserted at SHIFT cycle 6 of bin=2048 -> immediate ready=1, bcd=0, no valid within 20 cycles. A fresh start then yields 16'h2048.
REQ-032 BIN_W=16, DIG=5: bin=65535 -> bcd=20'h65535 after 17 cycles. DIG=4 with BIN_W=16 fails elaboration.
REQ-033 BIN2BCD_SIGNED_EN, BIN_W=12:
- bin=-2048 -> sign=1, bcd=16'h2048;
- bin=-1 -> sign=1, bcd=16'h0001;
- bin=2047 -> sign=0, bcd=16'h2047.
